// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the serial N-bit adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } adder_state_t;

    function automatic int adder_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic bit adder_cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

    // A single-chunk configuration still needs a 1-bit counter.
    function automatic int adder_cnt_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice.
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic c;

    // NOTE: blocking assignments here are intentional; c is a ripple temporary
    // that each loop iteration must see updated immediately.
    always_comb begin
        s = '0;
        c = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        co = c;
    end

endmodule

// File: rtl/adder_nbit_serial.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per clock, valid/ready on both sides.
// Optional signed-overflow output enabled by defining ADDER_SERIAL_OVF_EN.
module adder_nbit_serial
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = adder_nchunk(WIDTH, CHUNK);
    localparam int CNT_W  = adder_cnt_w(NCHUNK);

    if (!adder_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
        $error("adder_nbit_serial: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
    end

    adder_state_t     state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CHUNK-1:0]       chunk_s;
    logic                   chunk_co;
    logic [WIDTH+CHUNK-1:0] sum_shift;
    logic                   load;
    logic                   last_chunk;

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x  (a_q[CHUNK-1:0]),
        .y  (b_q[CHUNK-1:0]),
        .ci (carry_q),
        .s  (chunk_s),
        .co (chunk_co)
    );

    // New chunk enters at the MSB end; after NCHUNK steps chunk 0 sits at the LSBs.
    assign sum_shift  = {chunk_s, sum_q};
    assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                load     = in_valid;
            end
            RUN: begin
                sum_d   = sum_shift[WIDTH+CHUNK-1:CHUNK];
                carry_d = chunk_co;
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                cnt_d   = cnt_q + 1'b1;
                if (last_chunk) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    load        = in_valid;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    // NOTE: every register here is a small datapath flop, not a memory, so all
    // of them are cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = carry_q;
    assign out_valid = out_valid_q;

`ifdef ADDER_SERIAL_OVF_EN
    logic a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;

    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        if (load) begin
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
        end
        // The final chunk's top bit is the sum MSB.
        if (state_q == RUN && last_chunk) begin
            ovf_d = (a_msb_q == b_msb_q) && (chunk_s[CHUNK-1] != a_msb_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_nbit_serial.sv
// Self-checking bench: directed scenarios plus randomized operations against an
// arithmetic reference, on a 16/4 instance and a single-chunk 16/16 instance.
module tb_adder_nbit_serial;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, sum;
    logic         cin, cout;
    logic         d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [W-1:0] d_sum;
    logic         d_cout;
`ifdef ADDER_SERIAL_OVF_EN
    logic         ovf, d_ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adder_nbit_serial #(.WIDTH(W), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef ADDER_SERIAL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    adder_nbit_serial #(.WIDTH(W), .CHUNK(W)) dut_one (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .sum       (d_sum),
        .cout      (d_cout)
`ifdef ADDER_SERIAL_OVF_EN
        ,
        .ovf       (d_ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic logic [W:0] ref_full(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int unsigned t;
        t = int'(x) + int'(y) + int'(c);
        return t[W:0];
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int t;
        t = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (t > 32767) || (t < -32768);
    endfunction

    task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        check("in_ready_idle", in_ready, 1'b1);
        a = x; b = y; cin = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Called right after the acceptance edge; counts edges until out_valid.
    task automatic wait_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic c);
        int k = 0;
        logic [W:0] full;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        full = ref_full(x, y, c);
        check({tag, "_latency"}, k, 4);
        check({tag, "_sum"}, sum, full[W-1:0]);
        check({tag, "_cout"}, cout, full[W]);
`ifdef ADDER_SERIAL_OVF_EN
        check({tag, "_ovf"}, ovf, ref_ovf(x, y, c));
`endif
    endtask

    task automatic hold_done(input string tag, input int cycles, input logic [W:0] full);
        for (int h = 0; h < cycles; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a = W'($urandom); b = W'($urandom); cin = 1'b1;
            #1;
            check({tag, "_bp_in_ready"}, in_ready, 1'b0);
            tick();
            check({tag, "_bp_valid"}, out_valid, 1'b1);
            check({tag, "_bp_sum"}, {cout, sum}, full);
        end
        in_valid = 1'b0;
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        #1;
        check({tag, "_done_in_ready"}, in_ready, 1'b1);
        tick();
        out_ready = 1'b0;
        check({tag, "_consumed"}, out_valid, 1'b0);
        check({tag, "_idle_ready"}, in_ready, 1'b1);
    endtask

    task automatic single_chunk_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c);
        int k = 0;
        logic [W:0] full;
        check({tag, "_in_ready"}, d_in_ready, 1'b1);
        a = x; b = y; cin = c; d_in_valid = 1'b1;
        tick();
        d_in_valid = 1'b0;
        while (!d_out_valid && k < 20) begin
            tick();
            k++;
        end
        full = ref_full(x, y, c);
        check({tag, "_latency"}, k, 1);
        check({tag, "_sum"}, {d_cout, d_sum}, full);
`ifdef ADDER_SERIAL_OVF_EN
        check({tag, "_ovf"}, d_ovf, ref_ovf(x, y, c));
`endif
        d_out_ready = 1'b1;
        tick();
        d_out_ready = 1'b0;
        check({tag, "_consumed"}, d_out_valid, 1'b0);
    endtask

    initial begin
        logic [W-1:0] ca, cb, na, nb;
        logic         cc, nc, pending, seen;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        tick();
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_state", {out_valid, cout, sum}, '0);
        tick();
        rst = 1'b0;
        tick();

        accept(16'h0002, 16'h0006, 1'b0);
        check("run_in_ready", in_ready, 1'b0);
        wait_result("basic", 16'h0002, 16'h0006, 1'b0);
        consume("basic");

        accept(16'hFFFF, 16'h0001, 1'b0);
        wait_result("ripple", 16'hFFFF, 16'h0001, 1'b0);
        consume("ripple");

        accept(16'h000E, 16'h0000, 1'b1);
        wait_result("bp", 16'h000E, 16'h0000, 1'b1);
        hold_done("bp", 3, 17'h0000F);
        consume("bp");

        accept(16'h0003, 16'h0004, 1'b0);
        wait_result("b2b_first", 16'h0003, 16'h0004, 1'b0);
        a = 16'h0006; b = 16'h0004; cin = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_valid_low", out_valid, 1'b0);
        check("b2b_running", in_ready, 1'b0);
        wait_result("b2b_second", 16'h0006, 16'h0004, 1'b1);
        consume("b2b_second");

        accept(16'h1234, 16'h4321, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_valid", out_valid, 1'b0);
        check("rst_mid_sum", {cout, sum}, '0);
        check("rst_mid_in_ready", in_ready, 1'b1);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen |= out_valid;
        end
        check("rst_no_stale", seen, 1'b0);

        accept(16'h7FFF, 16'h0001, 1'b0);
        wait_result("ovf_pos", 16'h7FFF, 16'h0001, 1'b0);
        consume("ovf_pos");
        accept(16'h8000, 16'h8000, 1'b0);
        wait_result("ovf_neg", 16'h8000, 16'h8000, 1'b0);
        consume("ovf_neg");

        pending = 1'b0;
        ca = '0; cb = '0; cc = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!pending) begin
                ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom);
                accept(ca, cb, cc);
            end
            wait_result("rand", ca, cb, cc);
            hold_done("rand", int'($urandom_range(0, 2)), ref_full(ca, cb, cc));
            if ($urandom_range(0, 1) == 1) begin
                na = W'($urandom); nb = W'($urandom); nc = 1'($urandom);
                a = na; b = nb; cin = nc;
                in_valid = 1'b1; out_ready = 1'b1;
                tick();
                in_valid = 1'b0; out_ready = 1'b0;
                check("rand_b2b_valid_low", out_valid, 1'b0);
                ca = na; cb = nb; cc = nc;
                pending = 1'b1;
            end else begin
                consume("rand");
                pending = 1'b0;
            end
        end
        if (pending) begin
            wait_result("rand_tail", ca, cb, cc);
            consume("rand_tail");
        end

        single_chunk_op("one_basic", 16'h0002, 16'h0006, 1'b0);
        single_chunk_op("one_ripple", 16'hFFFF, 16'h0001, 1'b0);
        for (int i = 0; i < 6; i++) begin
            single_chunk_op("one_rand", W'($urandom), W'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/adder_nbit_serial.md
# adder_nbit_serial

Parametrised multi-cycle adder computing `sum = a + b + cin` on WIDTH-bit operands, CHUNK bits per clock, with a carry register between chunks. It succeeds the fixed 4-bit adder: width and per-cycle slice are parameters, and operands and results move over valid/ready handshakes. It sits between the operand registers and result consumers in datapaths that trade latency for a narrow carry chain.

## Interface
- `WIDTH`, default 16: operand and sum width. Must be a multiple of CHUNK.
- `CHUNK`, default 4: bits added per cycle. Range 1..WIDTH.
- Derived: `NCHUNK = WIDTH/CHUNK`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  operands `a`, `b` and `cin` are valid.
- `in_ready`  out  1  block can accept operands.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry in.
- `out_valid`  out  1  the result is valid.
- `out_ready`  in  1  the consumer accepts the result.
- `sum`  out  WIDTH  result.
- `cout`  out  1  carry out of the MSB.
- `ovf`  out  1  signed overflow. Present only with ADDER_SERIAL_OVF_EN.

## Operation
- **States** (registered): IDLE, RUN, DONE.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid`: capture `a`, `b` into shift registers and `cin` into the carry register, clear the chunk counter, go to RUN.
- **RUN**
  - `in_ready=0`.
  - Each cycle, add the low CHUNK bits of the A/B shift registers plus the carry register.
  - Shift the CHUNK-bit result into the sum register from the MSB end.
  - Update the carry register. Shift A/B right by CHUNK. Increment the counter.
  - After the chunk with counter `NCHUNK-1`, go to DONE.
- **DONE**
  - `out_valid=1`. `sum`, `cout` (final carry register) and `ovf` are held stable.
  - `in_ready = out_ready`, combinational from state and `out_ready`.
  - `out_ready=1` and `in_valid=0`: go to IDLE.
  - `out_ready=1` and `in_valid=1`: the result is consumed and new operands are captured on the same edge; go straight to RUN.
  - `out_ready=0`: stay in DONE and ignore `in_valid`.
- **Arithmetic**
  - Unsigned modulo 2^WIDTH. `cout` is bit WIDTH of the full sum.
  - `ovf = (a_msb == b_msb) && (sum_msb != a_msb)`, using operand MSBs captured at acceptance.
- **Counter**: width `$clog2(NCHUNK)`, minimum 1 bit. When `NCHUNK=1`, RUN lasts exactly one cycle.
- **Reset**
  - Asynchronous. Forces IDLE and clears all registers: `sum=0`, `cout=0`, `ovf=0`, `out_valid=0`, counter 0.
  - `in_ready=1` while in reset and afterwards.
  - Reset during RUN or DONE aborts the operation. No `out_valid` pulse follows.
- `in_valid` while `in_ready=0` is ignored. The source holds operands until a handshake occurs.

## Timing
- Acceptance edge E0: `in_valid & in_ready` sampled high.
- Chunk k is added at edge E(k+1), for k = 0..NCHUNK-1.
- `out_valid` is high from edge E(NCHUNK), so latency is NCHUNK cycles from acceptance to result.
- `out_valid` drops on the edge where `out_ready` is sampled high, unless a new operation started on that edge. In that case `out_valid` is also low after the edge, because the state is RUN.
- Peak throughput: one result per NCHUNK+1 cycles, using the DONE-to-RUN path.
- `out_valid`, `sum`, `cout`, `ovf` are registered outputs.
- `in_ready` is combinational: decoded from state, and from `out_ready` in DONE.

## Configuration
- Macro `ADDER_SERIAL_OVF_EN`.
- **Defined**:
  - The `ovf` port is present.
  - Operand MSB capture registers are instantiated.
  - `ovf` is valid whenever `out_valid=1`.
- **Undefined**: the `ovf` port and its registers are absent. All other behaviour is identical.

## Structure
- **Package `adder_pkg`**:
  - State enum `adder_state_t` (IDLE, RUN, DONE).
  - Function `adder_nchunk(WIDTH, CHUNK)`.
  - Elaboration check that WIDTH is divisible by CHUNK.
- **Sub-module `adder_chunk`**:
  - Combinational CHUNK-bit ripple adder.
  - Inputs: `x`, `y`, `ci`. Outputs: `s`, `co`.
  - Instantiated once in `adder_nbit_serial`.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 (NCHUNK=4) unless stated.
- **Basic add**: `a=0x0002`, `b=0x0006`, `cin=0` → `sum=0x0008`, `cout=0`, `out_valid` high exactly 4 cycles after acceptance.
- **Full carry ripple**: `a=0xFFFF`, `b=0x0001`, `cin=0` → `sum=0x0000`, `cout=1`. Carry propagates across all four chunks.
- **Backpressure**: `a=0x000E`, `b=0x0000`, `cin=1`, with `out_ready` held low 3 cycles in DONE → `sum=0x000F` stable, `in_ready=0`, a new `in_valid` is ignored. Release → IDLE.
- **Back-to-back**: in DONE with `out_ready=1` and `in_valid=1` (`0x0006+0x0004`, `cin=1`) → first result consumed and second operands accepted on the same edge. `out_valid` is low next cycle. `sum=0x000B` appears 4 cycles later.
- **Reset mid-operation**: assert `rst` 2 cycles into RUN → immediately `out_valid=0`, `sum=0`, `cout=0`, `in_ready=1`. No stale result after release.
- **Overflow and degenerate width**: with ADDER_SERIAL_OVF_EN, `0x7FFF+0x0001` → `ovf=1`, `cout=0`; `0x8000+0x8000` → `sum=0`, `cout=1`, `ovf=1`. Rerun the basic case with CHUNK=16 → latency 1.
